// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the FP multiplier normalise/shift stage.
// The stage-1 payload struct is sized from the package default widths, so the
// top-level EXPO_W/MANT_W parameters are expected to stay at these defaults.
package mul_pkg;

    localparam int MUL_EXPO_W = 8;
    localparam int MUL_MANT_W = 23;

    // Product width for a stored mantissa width: two (hidden+mantissa) factors.
    function automatic int pw_of(input int mant_w);
        return 2 * mant_w + 2;
    endfunction

    // Width of leading-zero and shift counts; must hold the value PW itself.
    function automatic int lzw_of(input int pw);
        return $clog2(pw) + 1;
    endfunction

    // Internal exponent width: two guard bits for overflow and negative range.
    function automatic int ew_of(input int expo_w);
        return expo_w + 2;
    endfunction

    localparam int MUL_PW   = pw_of(MUL_MANT_W);
    localparam int MUL_EW   = ew_of(MUL_EXPO_W);
    localparam int MUL_LZ_W = lzw_of(MUL_PW);

    typedef enum logic [1:0] {
        OVF  = 2'd0,
        ZERO = 2'd1,
        NORM = 2'd2,
        SUB  = 2'd3
    } norm_case_e;

    // Everything stage 2 needs to finish the beat without re-deriving anything.
    typedef struct packed {
        logic [MUL_EW-1:0]   expo;
        logic [MUL_PW-1:0]   mant;
        logic                ftz;
        norm_case_e          ncase;
        logic [MUL_LZ_W-1:0] lz;
        logic [MUL_LZ_W-1:0] shamt;
    } s1_payload_t;

endpackage

// File: rtl/mul_lzc.sv
// Combinational leading-zero counter. Counts zeros from the MSB of i_data
// downward; an all-zero input reports W and raises o_zero.
module mul_lzc
    import mul_pkg::*;
#(
    parameter int W     = MUL_PW - 1,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     i_data,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    // Ascending scan: the last set bit seen is the highest one, which sets the count.
    always_comb begin
        o_cnt  = CNT_W'(W);
        o_zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_cnt  = CNT_W'(W - 1 - i);
                o_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_norm_shift_pipe.sv
// Post-multiply normalise / subnormal-shift stage.
// Stage 1 classifies the product (overflow, zero, normal, subnormal), counts
// leading zeros and picks a shift amount. Stage 2 runs one barrel shifter with
// a sticky OR-reduce and registers the result for the rounder.
module mul_norm_shift_pipe
    import mul_pkg::*;
#(
    parameter int EXPO_W = MUL_EXPO_W,
    parameter int MANT_W = MUL_MANT_W,
    localparam int EW    = ew_of(EXPO_W),
    localparam int PW    = pw_of(MANT_W),
    localparam int LZ_W  = lzw_of(PW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] in_expo,
    input  logic [PW-1:0] in_mant,
    input  logic          in_ftz,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] out_expo,
    output logic [PW-1:0] out_mant,
    output logic          out_sticky,
    output logic          out_uflow,
    output logic          out_zero
);

    localparam logic signed [EW-1:0] EXPO_ZERO = '0;
    localparam logic signed [EW:0]   SAT_LIM   = (EW + 1)'(PW);

    // Right-shift amounts at or beyond PW all mean "everything falls into sticky".
    function automatic logic [LZ_W-1:0] sat_rshift(input logic signed [EW:0] amt);
        if (amt >= SAT_LIM) begin
            return LZ_W'(PW);
        end
        return LZ_W'(amt);
    endfunction

    // ------------------------------------------------------------------
    // Handshake: each stage can take a beat when empty or when draining.
    // ------------------------------------------------------------------
    logic w_ready_p1;
    logic w_ready_p2;
    logic r_vld_p1;
    logic r_vld_p2;

    assign w_ready_p2 = !r_vld_p2 || out_ready;
    assign w_ready_p1 = !r_vld_p1 || w_ready_p2;
    assign in_ready   = w_ready_p1;
    assign out_valid  = r_vld_p2;

    // ------------------------------------------------------------------
    // Stage 1 input side: classification and shift selection
    // ------------------------------------------------------------------
    logic [LZ_W-1:0]      w_lz;
    logic                 w_lz_allzero;
    logic signed [EW-1:0] w_expo_s;
    logic signed [EW-1:0] w_lz_s;
    logic signed [EW:0]   w_rsh_amt;
    norm_case_e           w_case;
    logic [LZ_W-1:0]      w_shamt;
    s1_payload_t          w_s1;
    s1_payload_t          r_s1_p1;

    mul_lzc #(
        .W     (PW - 1),
        .CNT_W (LZ_W)
    ) u_lzc (
        .i_data (in_mant[PW-2:0]),
        .o_cnt  (w_lz),
        .o_zero (w_lz_allzero)
    );

    assign w_expo_s  = $signed(in_expo);
    assign w_lz_s    = $signed(EW'(w_lz));
    // 1-expo needs one extra bit: the most negative exponent would otherwise wrap.
    assign w_rsh_amt = $signed((EW + 1)'(1)) - $signed({in_expo[EW-1], in_expo});

    // Pick the case and the single shift amount stage 2 will apply.
    always_comb begin
        w_case  = SUB;
        w_shamt = '0;
        if (in_mant[PW-1]) begin
            w_case  = OVF;
            w_shamt = LZ_W'(1);
        end else if (w_lz_allzero) begin
            w_case  = ZERO;
        end else if ((w_expo_s > EXPO_ZERO) && (w_expo_s > w_lz_s)) begin
            w_case  = NORM;
            w_shamt = w_lz;
        end else if (w_expo_s > EXPO_ZERO) begin
            // Partial left shift: stops where the exponent would reach zero.
            w_shamt = LZ_W'(in_expo - EW'(1));
        end else begin
            w_shamt = sat_rshift(w_rsh_amt);
        end
    end

    // Pack the stage-1 payload.
    always_comb begin
        w_s1       = '0;
        w_s1.expo  = in_expo;
        w_s1.mant  = in_mant;
        w_s1.ftz   = in_ftz;
        w_s1.ncase = w_case;
        w_s1.lz    = w_lz;
        w_s1.shamt = w_shamt;
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    // Stage-1 valid: cleared on reset so in-flight beats are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_ready_p1) begin
            r_vld_p1 <= in_valid;
        end
    end

    // Stage-1 payload: datapath only, qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (in_valid && w_ready_p1) begin
            r_s1_p1 <= w_s1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: barrel shift, sticky reduce, result selection
    // ------------------------------------------------------------------
    logic            w_rsh_full;
    logic [PW-1:0]   w_rmask;
    logic [PW-1:0]   w_rsh_mant;
    logic            w_rsh_sticky;
    logic [PW-1:0]   w_lsh_mant;
    logic            w_sub_left;
    logic [EW-1:0]   w_res_expo;
    logic [PW-1:0]   w_res_mant;
    logic            w_res_sticky;
    logic            w_res_uflow;
    logic            w_res_zero;

    assign w_rsh_full   = (r_s1_p1.shamt >= LZ_W'(PW));
    assign w_rmask      = w_rsh_full ? '1 : ((PW'(1) << r_s1_p1.shamt) - PW'(1));
    assign w_rsh_mant   = w_rsh_full ? '0 : (r_s1_p1.mant >> r_s1_p1.shamt);
    assign w_rsh_sticky = |(r_s1_p1.mant & w_rmask);
    assign w_lsh_mant   = r_s1_p1.mant << r_s1_p1.shamt;
    assign w_sub_left   = ($signed(r_s1_p1.expo) > EXPO_ZERO);

    // Select the result fields for the registered case.
    always_comb begin
        w_res_expo   = '0;
        w_res_mant   = '0;
        w_res_sticky = 1'b0;
        w_res_uflow  = 1'b0;
        case (r_s1_p1.ncase)
            OVF: begin
                // Shift amount is 1, so the sticky mask covers just bit 0.
                w_res_expo   = r_s1_p1.expo + EW'(1);
                w_res_mant   = w_rsh_mant;
                w_res_sticky = w_rsh_sticky;
            end
            NORM: begin
                w_res_expo = r_s1_p1.expo - EW'(r_s1_p1.lz);
                w_res_mant = w_lsh_mant;
            end
            SUB: begin
                w_res_uflow = 1'b1;
                if (!r_s1_p1.ftz) begin
                    if (w_sub_left) begin
                        w_res_mant = w_lsh_mant;
                    end else begin
                        w_res_mant   = w_rsh_mant;
                        w_res_sticky = w_rsh_sticky;
                    end
                end
            end
            default: begin
                // ZERO: everything stays cleared.
            end
        endcase
    end

    assign w_res_zero = (w_res_mant == '0);

    // ------------------------------------------------------------------
    // Stage 2 register: the module outputs
    // ------------------------------------------------------------------
    logic [EW-1:0] r_expo_p2;
    logic [PW-1:0] r_mant_p2;
    logic          r_sticky_p2;
    logic          r_uflow_p2;
    logic          r_zero_p2;

    // Output stage: hold while stalled, load when stage 1 hands a beat over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2    <= 1'b0;
            r_expo_p2   <= '0;
            r_mant_p2   <= '0;
            r_sticky_p2 <= 1'b0;
            r_uflow_p2  <= 1'b0;
            r_zero_p2   <= 1'b0;
        end else begin
            if (w_ready_p2) begin
                r_vld_p2 <= r_vld_p1;
            end
            if (r_vld_p1 && w_ready_p2) begin
                r_expo_p2   <= w_res_expo;
                r_mant_p2   <= w_res_mant;
                r_sticky_p2 <= w_res_sticky;
                r_uflow_p2  <= w_res_uflow;
                r_zero_p2   <= w_res_zero;
            end
        end
    end

    assign out_expo   = r_expo_p2;
    assign out_mant   = r_mant_p2;
    assign out_sticky = r_sticky_p2;
    assign out_uflow  = r_uflow_p2;
    assign out_zero   = r_zero_p2;

endmodule

// File: tb/tb_mul_norm_shift_pipe.sv
// Bench for mul_norm_shift_pipe at EXPO_W=8, MANT_W=23 (EW=10, PW=48).
// A reference model computes the expected result when a beat is accepted and
// queues it; results are popped and compared when the DUT hands one over.
module tb_mul_norm_shift_pipe;

    localparam int EW = 10;
    localparam int PW = 48;

    typedef struct packed {
        logic [EW-1:0] expo;
        logic [PW-1:0] mant;
        logic          sticky;
        logic          uflow;
        logic          zero;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] in_expo;
    logic [PW-1:0] in_mant;
    logic          in_ftz;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_expo;
    logic [PW-1:0] out_mant;
    logic          out_sticky;
    logic          out_uflow;
    logic          out_zero;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    mul_norm_shift_pipe #(
        .EXPO_W (8),
        .MANT_W (23)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_expo    (in_expo),
        .in_mant    (in_mant),
        .in_ftz     (in_ftz),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_expo   (out_expo),
        .out_mant   (out_mant),
        .out_sticky (out_sticky),
        .out_uflow  (out_uflow),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    // Reference: bit-serial right shift, explicit leading-zero scan.
    function automatic res_t model(input logic [EW-1:0] e, input logic [PW-1:0] m, input logic ftz);
        res_t        r;
        int          ex;
        int          lz;
        int          sh;
        logic [PW-1:0] mm;
        logic        st;
        r  = '0;
        ex = int'($signed(e));
        if (m[PW-1]) begin
            r.expo   = EW'(ex + 1);
            r.mant   = m >> 1;
            r.sticky = m[0];
        end else if (m != '0) begin
            lz = 0;
            while (m[PW-2-lz] == 1'b0) lz++;
            if (ex > lz) begin
                r.expo = EW'(ex - lz);
                r.mant = m << lz;
            end else begin
                r.uflow = 1'b1;
                if (!ftz) begin
                    if (ex >= 1) begin
                        r.mant = m << (ex - 1);
                    end else begin
                        sh = 1 - ex;
                        mm = m;
                        st = 1'b0;
                        for (int i = 0; i < sh && i < PW; i++) begin
                            st = st | mm[0];
                            mm = mm >> 1;
                        end
                        r.mant   = mm;
                        r.sticky = st;
                    end
                end
            end
        end
        r.zero = (r.mant == '0);
        return r;
    endfunction

    // One clock: at the falling edge record output/input transfers, then advance.
    task automatic tick(output bit popped, output res_t obs, output res_t expv, output bit acc);
        @(negedge clk);
        popped = 1'b0;
        acc    = 1'b0;
        obs    = '0;
        expv   = '0;
        if (out_valid && out_ready) begin
            popped = 1'b1;
            obs    = {out_expo, out_mant, out_sticky, out_uflow, out_zero};
            if (sb.size() > 0) expv = sb.pop_front();
            else expv = 'x;
        end
        if (in_valid && in_ready) begin
            acc = 1'b1;
            sb.push_back(model(in_expo, in_mant, in_ftz));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_expo   = '0;
        in_mant   = '0;
        in_ftz    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++;
        if ({out_expo, out_mant, out_sticky, out_uflow, out_zero} !== '0) begin
            errors++; $display("FAIL rst_outputs: got %h %h %b%b%b expected all zero", out_expo, out_mant, out_sticky, out_uflow, out_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_vectors();
        logic [EW-1:0] ve[13];
        logic [PW-1:0] vm[13];
        logic          vf[13];
        res_t          vx[13];
        bit            popped, acc;
        res_t          obs, expv;
        int            k, n;
        ve[0]  = 10'd100;  vm[0]  = 48'h8000_0000_0001; vf[0]  = 0; vx[0]  = {10'd101, 48'h4000_0000_0000, 1'b1, 1'b0, 1'b0};
        ve[1]  = 10'd100;  vm[1]  = 48'h0000_4000_0000; vf[1]  = 0; vx[1]  = {10'd84,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0};
        ve[2]  = 10'd10;   vm[2]  = 48'h0000_4000_0000; vf[2]  = 0; vx[2]  = {10'd0,   48'h0080_0000_0000, 1'b0, 1'b1, 1'b0};
        ve[3]  = 10'd10;   vm[3]  = 48'h0000_4000_0000; vf[3]  = 1; vx[3]  = {10'd0,   48'h0,              1'b0, 1'b1, 1'b1};
        ve[4]  = 10'h3FD;  vm[4]  = 48'h4000_0000_0003; vf[4]  = 0; vx[4]  = {10'd0,   48'h0400_0000_0000, 1'b1, 1'b1, 1'b0};
        ve[5]  = 10'h3C4;  vm[5]  = 48'h4000_0000_0003; vf[5]  = 0; vx[5]  = {10'd0,   48'h0,              1'b1, 1'b1, 1'b1};
        ve[6]  = 10'd50;   vm[6]  = 48'h0;              vf[6]  = 0; vx[6]  = {10'd0,   48'h0,              1'b0, 1'b0, 1'b1};
        ve[7]  = 10'd1;    vm[7]  = 48'h0000_4000_0000; vf[7]  = 0; vx[7]  = {10'd0,   48'h0000_4000_0000, 1'b0, 1'b1, 1'b0};
        ve[8]  = 10'd0;    vm[8]  = 48'h4000_0000_0000; vf[8]  = 0; vx[8]  = {10'd0,   48'h2000_0000_0000, 1'b0, 1'b1, 1'b0};
        ve[9]  = 10'h3D2;  vm[9]  = 48'h4000_0000_0003; vf[9]  = 0; vx[9]  = {10'd0,   48'h0,              1'b1, 1'b1, 1'b1};
        ve[10] = 10'h3D1;  vm[10] = 48'h4000_0000_0003; vf[10] = 0; vx[10] = {10'd0,   48'h0,              1'b1, 1'b1, 1'b1};
        ve[11] = 10'd17;   vm[11] = 48'h0000_4000_0000; vf[11] = 0; vx[11] = {10'd1,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0};
        ve[12] = 10'd16;   vm[12] = 48'h0000_4000_0000; vf[12] = 0; vx[12] = {10'd0,   48'h2000_0000_0000, 1'b0, 1'b1, 1'b0};
        k = 0;
        n = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 13; cyc++) begin
            if (k < 13) begin
                in_valid = 1'b1; in_expo = ve[k]; in_mant = vm[k]; in_ftz = vf[k];
            end else begin
                in_valid = 1'b0;
            end
            tick(popped, obs, expv, acc);
            if (acc) k++;
            if (popped) begin
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL vec_model[%0d]: got %h expected %h", n, obs, expv); end
                checks++;
                if (obs !== vx[n]) begin errors++; $display("FAIL vec_const[%0d]: got %h expected %h", n, obs, vx[n]); end
                n++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n != 13) begin errors++; $display("FAIL vec_count: got %0d results expected 13", n); end
    endtask

    task automatic test_latency();
        bit   popped, acc;
        res_t obs, expv;
        int   lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_expo   = 10'd100;
        in_mant   = 48'h0000_4000_0000;
        in_ftz    = 1'b0;
        tick(popped, obs, expv, acc);
        in_valid = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL lat_accept: got %b expected 1", acc); end
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick(popped, obs, expv, acc);
            lat++;
        end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL lat_cycles: got %0d expected 2", lat); end
        tick(popped, obs, expv, acc);
        checks++;
        if (!popped || obs !== {10'd84, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL lat_result: got %h (popped %b) expected %h", obs, popped, {10'd84, 48'h4000_0000_0000, 3'b000});
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        bit   popped, acc;
        res_t obs, expv, hold;
        int   k, n;
        k = 0;
        n = 0;
        hold = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = (cyc >= 5);
            if (k < 4) begin
                in_valid = 1'b1;
                in_expo  = EW'(100 + k);
                in_mant  = 48'h0000_4000_0000 << k;
                in_ftz   = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", cyc, in_ready); end
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", cyc, out_valid); end
            end
            if (cyc == 2) hold = {out_expo, out_mant, out_sticky, out_uflow, out_zero};
            if (cyc == 3 || cyc == 4) begin
                checks++;
                if ({out_expo, out_mant, out_sticky, out_uflow, out_zero} !== hold) begin
                    errors++; $display("FAIL bp_stable[%0d]: got %h expected %h", cyc, {out_expo, out_mant, out_sticky, out_uflow, out_zero}, hold);
                end
            end
            tick(popped, obs, expv, acc);
            if (acc) k++;
            if (popped) begin
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", n, obs, expv); end
                n++;
            end
            if (n == 4) break;
        end
        in_valid = 1'b0;
        checks++;
        if (n != 4 || k != 4 || sb.size() != 0) begin
            errors++; $display("FAIL bp_count: got in=%0d out=%0d left=%0d expected 4 4 0", k, n, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        bit   popped, acc;
        res_t obs, expv;
        int   lat;
        out_ready = 1'b1;
        in_ftz    = 1'b0;
        in_valid  = 1'b1; in_expo = 10'd100; in_mant = 48'h8000_0000_0001;
        tick(popped, obs, expv, acc);
        in_valid  = 1'b1; in_expo = 10'd10;  in_mant = 48'h0000_4000_0000;
        tick(popped, obs, expv, acc);
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: got %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
        checks++;
        if ({out_expo, out_mant, out_sticky, out_uflow, out_zero} !== '0) begin
            errors++; $display("FAIL mid_async_out: got %h %h expected zero", out_expo, out_mant);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_drop: got %b expected 0", out_valid); end
        in_valid = 1'b1; in_expo = 10'h3FD; in_mant = 48'h4000_0000_0003;
        tick(popped, obs, expv, acc);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick(popped, obs, expv, acc);
            lat++;
        end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL mid_latency: got %0d expected 2", lat); end
        tick(popped, obs, expv, acc);
        checks++;
        if (!popped || obs !== {10'd0, 48'h0400_0000_0000, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mid_result: got %h (popped %b) expected %h", obs, popped, {10'd0, 48'h0400_0000_0000, 3'b110});
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        localparam int N = 300;
        bit          popped, acc, stalled;
        res_t        obs, expv, prev;
        logic [63:0] rnd;
        int          sent, rcv, e;
        sent = 0;
        rcv  = 0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 4000 && rcv < N; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < N && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                rnd = {$urandom(), $urandom()};
                case ($urandom_range(0, 9))
                    0:       in_mant = '0;
                    1:       in_mant = {1'b1, rnd[46:0]};
                    2, 3, 4: in_mant = {1'b0, rnd[46:0]} >> $urandom_range(0, 46);
                    default: in_mant = {1'b0, rnd[46:0]};
                endcase
                if ($urandom_range(0, 1) == 0) begin
                    e = int'($urandom_range(0, 120)) - 60;
                    in_expo = EW'(e);
                end else begin
                    in_expo = EW'($urandom_range(0, 1023));
                end
                in_ftz = ($urandom_range(0, 3) == 0);
            end
            prev    = {out_expo, out_mant, out_sticky, out_uflow, out_zero};
            stalled = out_valid && !out_ready;
            tick(popped, obs, expv, acc);
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            if (popped) begin
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", rcv, obs, expv); end
                rcv++;
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {out_expo, out_mant, out_sticky, out_uflow, out_zero} !== prev) begin
                    errors++; $display("FAIL b2b_hold: got %b %h expected 1 %h", out_valid, {out_expo, out_mant, out_sticky, out_uflow, out_zero}, prev);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (rcv != N || sb.size() != 0) begin
            errors++; $display("FAIL b2b_count: got %0d results, %0d queued, expected %0d and 0", rcv, sb.size(), N);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_latency();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
